me_sched: RTL and testbench
===========================

# me_sched

Frame-level scheduler for the motion-estimation engine `me`. It walks a frame's macroblocks in raster order and sequences each one through three steps:
- request the search-window/current-MB BRAM load,
- start `me` and wait for its completion,
- capture the motion vector and minimum SAD and hand them downstream over a valid/ready port.

It owns the `me` start/done handshake, so the engine processes exactly one macroblock at a time.

## Interface
Parameters:
- MACRO_DIM, 16, macroblock edge in pixels (passed through for documentation and window sizing; not used arithmetically)
- SEARCH_DIM, 48, search window edge in pixels
- FRAME_W_MB, 20, frame width in macroblocks (1..255)
- FRAME_H_MB, 15, frame height in macroblocks (1..255)
- TIMEOUT_CYC, 4096, maximum cycles allowed in RUN before the macroblock is aborted (≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse that begins a frame
- load_req  out  1  request BRAM load for macroblock (load_mb_x, load_mb_y)
- load_mb_x  out  8  macroblock column being loaded/processed
- load_mb_y  out  8  macroblock row being loaded/processed
- load_ack  in  1  load complete; valid only while load_req=1
- me_start  out  1  one-cycle start pulse to `me`
- me_done  in  1  `me` done level; only its rising edge is used
- me_mv_x  in  6  `me` horizontal vector
- me_mv_y  in  6  `me` vertical vector
- me_min_sad  in  16  `me` minimum SAD
- res_valid  out  1  result register holds a result
- res_ready  in  1  downstream accepts the result
- res_mb_x  out  8  result macroblock column
- res_mb_y  out  8  result macroblock row
- res_mv_x  out  6  result horizontal vector
- res_mv_y  out  6  result vertical vector
- res_sad  out  16  result SAD
- res_err  out  1  result was produced by timeout
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse after the last result is accepted

## Operation
- States: IDLE, LOAD, START, RUN, OUT.
- IDLE: all request outputs low. On frame_start=1: mb_x=0, mb_y=0, go to LOAD.
  - frame_start in any other state is ignored.
- LOAD: load_req=1; load_mb_x/y hold the current macroblock. On load_ack=1, go to START.
- START: me_start=1 for exactly one cycle, then RUN. Clear the RUN cycle counter.
- RUN:
  - Register me_done into done_q each cycle (done_q reset 0).
  - On the rising edge me_done & ~done_q: capture mv_x/mv_y/min_sad and the current mb_x/y into the result registers, set res_err=0, go to OUT.
  - Timeout: if the counter reaches TIMEOUT_CYC-1 with no rising edge, capture res_mv_x=0, res_mv_y=0, res_sad=16'hFFFF, res_err=1, go to OUT.
  - If the edge and the timeout occur in the same cycle, the edge wins.
- OUT: res_valid=1 and result fields stable. On res_ready=1, advance position:
  - If mb_x<FRAME_W_MB-1: mb_x+1, go to LOAD.
  - Else if mb_y<FRAME_H_MB-1: mb_x=0, mb_y+1, go to LOAD.
  - Else go to IDLE and pulse frame_done for one cycle.
- Counters are 8-bit with no wrap in legal use. The RUN counter is 16-bit and saturating.
- All outputs are registered (Moore). Outputs never depend combinationally on inputs.

## Timing
- Reset value of every output is 0. Reset returns the state to IDLE, clears mb_x/y, the counter and done_q, and clears the result registers.
- Reset asserted mid-frame aborts immediately. No frame_done is issued.
- Cycle 0: frame_start sampled. Cycle 1: load_req=1, busy=1.
- load_ack sampled at cycle k → me_start=1 at k+1 and 0 at k+2.
- Rising edge of me_done sampled at cycle n → res_valid=1 at n+1.
- res_ready sampled high with res_valid at cycle r, then at r+1:
  - res_valid=0, and
  - either load_req=1 for the next macroblock, or frame_done=1 and busy=0.
- me_done held high from a previous macroblock is not re-accepted; a fresh low→high transition is required.
- res_valid holds, with result fields unchanged, for any number of res_ready=0 cycles.

## Test plan
- 1×1 frame, load_ack 2 cycles after load_req, me_done rises 10 cycles after me_start with mv=(3,5), sad=0x0123 → exactly one result (0,0,3,5,0x0123,err=0), then frame_done pulse; busy returns 0.
- 2×2 frame, zero-latency ack and done after 4 cycles → results in order (0,0),(1,0),(0,1),(1,1); exactly four me_start pulses; frame_done after the fourth acceptance.
- 2×2 frame, res_ready low for 7 cycles on the second result → res_valid and fields held stable; no load_req for (0,1) until the cycle after acceptance.
- TIMEOUT_CYC=16, me_done never rises → result sad=0xFFFF, mv=(0,0), err=1 after 16 RUN cycles; the frame continues normally.
- frame_start pulsed during RUN, and me_done held high across me_start → the extra start is ignored, and the stale done level is not accepted until it falls and rises again.
- rst_n low during OUT of the second macroblock → all outputs 0 asynchronously; a new frame_start after release restarts at (0,0).

Source files
------------

// File: rtl/me_sched_if.sv
// Handshake bundle between me_sched and its BRAM loader, the me engine and the result sink.
interface me_sched_if;
  logic        load_req;
  logic [7:0]  load_mb_x;
  logic [7:0]  load_mb_y;
  logic        load_ack;
  logic        me_start;
  logic        me_done;
  logic [5:0]  me_mv_x;
  logic [5:0]  me_mv_y;
  logic [15:0] me_min_sad;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_mb_x;
  logic [7:0]  res_mb_y;
  logic [5:0]  res_mv_x;
  logic [5:0]  res_mv_y;
  logic [15:0] res_sad;
  logic        res_err;

  modport master (
    output load_req, load_mb_x, load_mb_y, me_start,
           res_valid, res_mb_x, res_mb_y, res_mv_x, res_mv_y, res_sad, res_err,
    input  load_ack, me_done, me_mv_x, me_mv_y, me_min_sad, res_ready
  );

  modport slave (
    input  load_req, load_mb_x, load_mb_y, me_start,
           res_valid, res_mb_x, res_mb_y, res_mv_x, res_mv_y, res_sad, res_err,
    output load_ack, me_done, me_mv_x, me_mv_y, me_min_sad, res_ready
  );
endinterface

// File: rtl/me_sched.sv
// Raster-order macroblock scheduler: load -> start me -> wait done/timeout -> hand off result.
module me_sched #(
  parameter int MACRO_DIM   = 16,
  parameter int SEARCH_DIM  = 48,
  parameter int FRAME_W_MB  = 20,
  parameter int FRAME_H_MB  = 15,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  me_sched_if.master bus,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, OUT} state_e;

  typedef struct packed {
    logic [7:0]  mb_x;
    logic [7:0]  mb_y;
    logic [5:0]  mv_x;
    logic [5:0]  mv_y;
    logic [15:0] sad;
    logic        err;
  } res_t;

  localparam logic [7:0]  X_LAST   = 8'(FRAME_W_MB - 1);
  localparam logic [7:0]  Y_LAST   = 8'(FRAME_H_MB - 1);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [7:0]  mb_x_q, mb_x_d;
  logic [7:0]  mb_y_q, mb_y_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q;
  res_t        res_q, res_d;
  logic        fdone_d;
  logic        load_req_q, me_start_q, res_valid_q, busy_q, frame_done_q;

  // Window geometry is carried for documentation only.
  logic unused_geom;
  assign unused_geom = ^{32'(MACRO_DIM), 32'(SEARCH_DIM)};

  always_comb begin
    state_d = state_q;
    mb_x_d  = mb_x_q;
    mb_y_d  = mb_y_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    fdone_d = 1'b0;
    case (state_q)
      IDLE: if (frame_start) begin
        mb_x_d  = '0;
        mb_y_d  = '0;
        state_d = LOAD;
      end
      LOAD: if (bus.load_ack) state_d = START;
      START: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // A done edge beats a simultaneous timeout.
        if (bus.me_done && !done_q) begin
          res_d = '{mb_x: mb_x_q, mb_y: mb_y_q, mv_x: bus.me_mv_x,
                    mv_y: bus.me_mv_y, sad: bus.me_min_sad, err: 1'b0};
          state_d = OUT;
        end else if (cnt_q == CNT_LAST) begin
          res_d = '{mb_x: mb_x_q, mb_y: mb_y_q, mv_x: 6'd0,
                    mv_y: 6'd0, sad: 16'hFFFF, err: 1'b1};
          state_d = OUT;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      OUT: if (bus.res_ready) begin
        if (mb_x_q != X_LAST) begin
          mb_x_d  = mb_x_q + 8'd1;
          state_d = LOAD;
        end else if (mb_y_q != Y_LAST) begin
          mb_x_d  = '0;
          mb_y_d  = mb_y_q + 8'd1;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
          fdone_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mb_x_q       <= '0;
      mb_y_q       <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      res_q        <= '0;
      load_req_q   <= 1'b0;
      me_start_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mb_x_q       <= mb_x_d;
      mb_y_q       <= mb_y_d;
      cnt_q        <= cnt_d;
      done_q       <= bus.me_done;
      res_q        <= res_d;
      load_req_q   <= (state_d == LOAD);
      me_start_q   <= (state_d == START);
      res_valid_q  <= (state_d == OUT);
      busy_q       <= (state_d != IDLE);
      frame_done_q <= fdone_d;
    end
  end

  assign bus.load_req  = load_req_q;
  assign bus.load_mb_x = mb_x_q;
  assign bus.load_mb_y = mb_y_q;
  assign bus.me_start  = me_start_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_mb_x  = res_q.mb_x;
  assign bus.res_mb_y  = res_q.mb_y;
  assign bus.res_mv_x  = res_q.mv_x;
  assign bus.res_mv_y  = res_q.mv_y;
  assign bus.res_sad   = res_q.sad;
  assign bus.res_err   = res_q.err;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_me_sched.sv
// Directed bench: a 1x1-frame scheduler and a 2x2-frame scheduler (16-cycle timeout).
module tb_me_sched;
  logic clk = 1'b0;
  logic rst_n;
  logic frame_start_a, frame_start_b;
  logic busy_a, busy_b, frame_done_a, frame_done_b;
  int   checks = 0;
  int   failures = 0;
  int   starts_b = 0;
  int   s0;

  always #5 clk = ~clk;

  me_sched_if ia();
  me_sched_if ib();

  me_sched #(.FRAME_W_MB(1), .FRAME_H_MB(1), .TIMEOUT_CYC(16)) ua (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start_a), .bus(ia.master),
    .busy(busy_a), .frame_done(frame_done_a));

  me_sched #(.FRAME_W_MB(2), .FRAME_H_MB(2), .TIMEOUT_CYC(16)) ub (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start_b), .bus(ib.master),
    .busy(busy_b), .frame_done(frame_done_b));

  always @(negedge clk) if (ib.me_start === 1'b1) starts_b++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: done 4 cycles after start; 1: never done (timeout);
  // 2: done held high on entry, frame_start pulsed in RUN; 3: stop in OUT without accepting.
  task automatic mb_b(input logic [7:0] x, input logic [7:0] y, input int mode,
                      input logic [5:0] mx, input logic [5:0] my, input logic [15:0] sd,
                      input int hold);
    int n;
    logic [5:0] ex_mx, ex_my;
    logic [15:0] ex_sd;
    logic ex_err;
    n = 0;
    while (ib.load_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("load_latency", n, 0);
    chk("load_xy", {ib.load_mb_x, ib.load_mb_y}, {x, y});
    ib.load_ack = 1'b1;
    @(negedge clk); ib.load_ack = 1'b0;
    chk("me_start_hi", ib.me_start, 1);
    @(negedge clk);
    chk("me_start_lo", ib.me_start, 0);
    if (mode == 1) begin
      repeat (15) @(negedge clk);
      chk("timeout_early", ib.res_valid, 0);
    end else if (mode == 2) begin
      frame_start_b = 1'b1;
      @(negedge clk); frame_start_b = 1'b0;
      repeat (4) @(negedge clk);
      chk("stale_done", ib.res_valid, 0);
      ib.me_done = 1'b0;
      @(negedge clk);
      chk("stale_fall", ib.res_valid, 0);
      ib.me_done = 1'b1; ib.me_mv_x = mx; ib.me_mv_y = my; ib.me_min_sad = sd;
    end else begin
      repeat (3) @(negedge clk);
      chk("no_early_valid", ib.res_valid, 0);
      ib.me_done = 1'b1; ib.me_mv_x = mx; ib.me_mv_y = my; ib.me_min_sad = sd;
    end
    @(negedge clk);
    ex_err = (mode == 1);
    ex_mx  = ex_err ? 6'd0 : mx;
    ex_my  = ex_err ? 6'd0 : my;
    ex_sd  = ex_err ? 16'hFFFF : sd;
    ib.me_done = 1'b0;
    chk("res_valid", ib.res_valid, 1);
    chk("res_pos", {ib.res_mb_x, ib.res_mb_y}, {x, y});
    chk("res_mv_err", {ib.res_mv_x, ib.res_mv_y, ib.res_err}, {ex_mx, ex_my, ex_err});
    chk("res_sad", ib.res_sad, ex_sd);
    if (mode == 3) return;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", ib.res_valid, 1);
      chk("hold_fields", {ib.res_mb_x, ib.res_mb_y, ib.res_sad}, {x, y, ex_sd});
      chk("hold_no_load", ib.load_req, 0);
    end
    ib.res_ready = 1'b1;
    @(negedge clk); ib.res_ready = 1'b0;
    chk("valid_drop", ib.res_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    frame_start_a = 1'b0; frame_start_b = 1'b0;
    ia.load_ack = 1'b0; ia.me_done = 1'b0; ia.me_mv_x = '0; ia.me_mv_y = '0;
    ia.me_min_sad = '0; ia.res_ready = 1'b0;
    ib.load_ack = 1'b0; ib.me_done = 1'b0; ib.me_mv_x = '0; ib.me_mv_y = '0;
    ib.me_min_sad = '0; ib.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_a_ctl", {ia.load_req, ia.me_start, ia.res_valid, busy_a, frame_done_a, ia.res_err}, 0);
    chk("rst_a_dat", {ia.load_mb_x, ia.res_mb_x, ia.res_sad}, 0);
    chk("rst_b_ctl", {ib.load_req, ib.me_start, ib.res_valid, busy_b, frame_done_b, ib.res_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1x1 frame: ack two cycles after load_req, done ten cycles after start
    frame_start_a = 1'b1;
    @(negedge clk); frame_start_a = 1'b0;
    chk("a_load_req", {ia.load_req, busy_a}, 2'b11);
    chk("a_load_xy", {ia.load_mb_x, ia.load_mb_y}, 0);
    @(negedge clk);
    chk("a_wait_ack", {ia.load_req, ia.me_start}, 2'b10);
    @(negedge clk); ia.load_ack = 1'b1;
    @(negedge clk); ia.load_ack = 1'b0;
    chk("a_me_start", {ia.me_start, ia.load_req}, 2'b10);
    @(negedge clk);
    chk("a_me_start_lo", ia.me_start, 0);
    repeat (9) @(negedge clk);
    chk("a_no_early", ia.res_valid, 0);
    ia.me_done = 1'b1; ia.me_mv_x = 6'd3; ia.me_mv_y = 6'd5; ia.me_min_sad = 16'h0123;
    @(negedge clk);
    chk("a_res_valid", ia.res_valid, 1);
    chk("a_res", {ia.res_mb_x, ia.res_mb_y, ia.res_mv_x, ia.res_mv_y, ia.res_err},
        {8'd0, 8'd0, 6'd3, 6'd5, 1'b0});
    chk("a_res_sad", ia.res_sad, 16'h0123);
    ia.res_ready = 1'b1; ia.me_done = 1'b0;
    @(negedge clk); ia.res_ready = 1'b0;
    chk("a_frame_done", {ia.res_valid, frame_done_a, busy_a}, 3'b010);
    @(negedge clk);
    chk("a_fd_pulse", {frame_done_a, ia.load_req}, 0);

    // 2x2 frame, zero-latency ack, ready held off 7 cycles on the second result
    frame_start_b = 1'b1;
    s0 = starts_b;
    @(negedge clk); frame_start_b = 1'b0;
    mb_b(8'd0, 8'd0, 0, 6'd1, 6'd2, 16'h0010, 0);
    mb_b(8'd1, 8'd0, 0, 6'd3, 6'd4, 16'h0020, 7);
    mb_b(8'd0, 8'd1, 0, 6'd5, 6'd6, 16'h0030, 0);
    mb_b(8'd1, 8'd1, 0, 6'h3F, 6'h20, 16'h0040, 0);
    chk("b_frame_done", {frame_done_b, busy_b, ib.load_req}, 3'b100);
    chk("b_start_count", starts_b - s0, 4);
    @(negedge clk);
    chk("b_fd_pulse", frame_done_b, 0);

    // timeout, then stale done level plus ignored frame_start
    frame_start_b = 1'b1;
    @(negedge clk); frame_start_b = 1'b0;
    mb_b(8'd0, 8'd0, 1, 6'd7, 6'd7, 16'h1234, 0);
    ib.me_done = 1'b1;
    mb_b(8'd1, 8'd0, 2, 6'd9, 6'd10, 16'h0BEE, 0);
    mb_b(8'd0, 8'd1, 0, 6'd11, 6'd12, 16'h0050, 0);
    mb_b(8'd1, 8'd1, 0, 6'd13, 6'd14, 16'h0060, 0);
    chk("b2_frame_done", {frame_done_b, busy_b}, 2'b10);
    @(negedge clk);

    // reset while the second macroblock sits in OUT
    frame_start_b = 1'b1;
    @(negedge clk); frame_start_b = 1'b0;
    mb_b(8'd0, 8'd0, 0, 6'd1, 6'd1, 16'h0070, 0);
    mb_b(8'd1, 8'd0, 3, 6'd2, 6'd2, 16'h0080, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl", {ib.load_req, ib.me_start, ib.res_valid, busy_b, frame_done_b, ib.res_err}, 0);
    chk("rst_mid_dat", {ib.load_mb_x, ib.res_mb_x, ib.res_sad}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_no_fd", {frame_done_b, busy_b}, 0);
    frame_start_b = 1'b1;
    @(negedge clk); frame_start_b = 1'b0;
    chk("restart_load", {ib.load_req, ib.load_mb_x, ib.load_mb_y}, {1'b1, 16'h0000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
